glb_host_sequencer: RTL and testbench
=====================================

Name: glb_host_sequencer

Overview:
- Synthesizable host-side sequencer for main_local; replaces hand-written bench stimulus.
- Weight and iact words arrive on a valid/ready input stream. The block writes them into the GLB write ports, then runs the weight and iact load phases.
- It then runs NUM_ITER compute passes and streams each pass's X_dim psums out on a valid/ready output stream.
- Parametrised in data/address width, tile sizes, base addresses and iteration count.

Parameters:
- DATA_BITWIDTH, 16, word width of GLB data and both streams.
- ADDR_BITWIDTH, 6, GLB address width.
- W_LOAD_ADDR, 0, first weight GLB address.
- A_LOAD_ADDR, 10, first iact GLB address.
- PSUM_LOAD_ADDR, 0, first psum address of iteration 0.
- X_dim, 3, psums read per iteration.
- kernel_size, 3, weights loaded = kernel_size**2.
- act_size, 5, iacts loaded = act_size**2.
- NUM_ITER, 3, compute passes per run (>=1).
- VAL_EXTRA, 3, extra val_enable cycles beyond the word count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- go  in  1  1-cycle pulse; starts a run from IDLE, ignored otherwise
- in_valid  in  1  input word valid
- in_ready  out  1  high in WR_WGHT/WR_IACT
- in_data  in  DATA_BITWIDTH  weight words, then iact words
- out_valid  out  1  psum word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_BITWIDTH  psum word
- out_last  out  1  last psum of the last iteration
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse on DONE
- write_en_wght  out  1  GLB weight write enable
- w_addr_wght  out  ADDR_BITWIDTH  GLB weight write address
- w_data_wght  out  DATA_BITWIDTH  GLB weight write data
- write_en_iact  out  1  GLB iact write enable
- w_addr_iact  out  ADDR_BITWIDTH  GLB iact write address
- w_data_iact  out  DATA_BITWIDTH  GLB iact write data
- val_enable_i_val_0_wght  out  1  weight load enable
- val_enable_i_val_0_iact  out  1  iact load enable
- start  out  1  compute start pulse
- load_done  in  1  accelerator load complete (level)
- compute_done  in  1  accelerator compute complete (level)
- val_0_req_read_psum  out  1  psum read request
- r_addr_psum  out  ADDR_BITWIDTH  psum read address
- r_data_psum  in  DATA_BITWIDTH  psum data, valid 1 cycle after request

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-run aborts immediately; no pending write or read completes.
- States: IDLE -> WR_WGHT -> WR_IACT -> VAL_WGHT -> WAIT_WLD -> VAL_IACT -> WAIT_ILD -> START -> WAIT_CMP -> RD_REQ -> RD_CAP -> RD_OUT -> (RD_REQ | START | DONE) -> IDLE.
- WR_WGHT / WR_IACT:
  - Each in_valid&in_ready handshake registers a write one cycle later: write_en=1, addr=base+count, data=in_data.
  - Address arithmetic is modulo 2**ADDR_BITWIDTH.
  - Leave the state after kernel_size**2 (resp. act_size**2) handshakes; in_ready drops in the cycle following the last handshake.
- VAL_WGHT / VAL_IACT: the load enable is held high for exactly N+VAL_EXTRA cycles (N = word count for that phase), then cleared.
- WAIT_WLD / WAIT_ILD: advance on a rising edge of load_done, detected against a registered copy. A load_done level left over from a previous phase does not advance the state.
- START: start=1 for exactly one cycle.
- WAIT_CMP: advance on a rising edge of compute_done.
- RD_REQ: val_0_req_read_psum=1 for one cycle, r_addr_psum = PSUM_LOAD_ADDR + iter*X_dim + col (modulo 2**ADDR_BITWIDTH).
- RD_CAP: r_data_psum is captured into out_data.
- RD_OUT:
  - out_valid held until out_ready; out_data stable while out_valid && !out_ready.
  - After the handshake: col++; if col==X_dim then iter++ and col=0.
  - Next state: RD_REQ if the iteration is unfinished, START if iter<NUM_ITER, else DONE.
- out_last=1 with out_valid on the word with iter==NUM_ITER-1 and col==X_dim-1.
- DONE: done=1 for one cycle, then IDLE. A go arriving while busy is ignored.
- Throughput: one psum per 3 cycles with out_ready held high.

Optional Feature:
- Macro: GLB_HOST_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycle_count [31:0], cleared on go and counting every cycle while busy.
  - The count freezes at DONE and saturates at 2**32-1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load: go, 9 weights all =1, then iacts 1..25 -> writes at wght addr 0..8 data 1, iact addr 10..34 data 1..25, one per handshake, with in_valid toggling randomly.
- Load enable timing: after the writes -> val_enable_i_val_0_wght high exactly 12 cycles; val_enable_i_val_0_iact high exactly 28 cycles, and only after a load_done rising edge.
- Stale level: load_done tied high through the weight phase -> sequencer stalls in WAIT_WLD until load_done falls and rises again.
- Three iterations with model returning psum=addr*7 -> out_data sequence 0,7,...,56 at read addresses 0..8; out_last only on the 9th word; one done pulse.
- Backpressure: out_ready low for 5 cycles mid-stream -> out_data held, no read request issued, no word lost or duplicated.
- Reset asserted in WAIT_CMP -> all outputs 0 asynchronously; a fresh go then reruns the full sequence correctly.

Source files
------------

// File: rtl/glb_host_sequencer.sv
// -----------------------------------------------------------------------------
// glb_host_sequencer
//
// Host-side sequencer for main_local. It accepts weight and iact words on a
// valid/ready stream and writes them into the GLB write ports. It then runs the
// weight and iact load phases and NUM_ITER compute passes. After each pass it
// reads X_dim psums back and streams them out on a valid/ready stream.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   go                          1-cycle start pulse (honoured only in IDLE)
//   in_valid/in_ready/in_data   input word stream (weights first, then iacts)
//   out_valid/out_ready/out_data/out_last
//                               psum output stream; out_last marks the final
//                               psum of the final pass
//   busy, done                  status: busy while not IDLE, done for 1 cycle
//   write_en_*/w_addr_*/w_data_*
//                               GLB weight / iact write ports
//   val_enable_i_val_0_wght/iact
//                               load-phase enables
//   start                       compute start pulse
//   load_done, compute_done     accelerator status levels (edge-detected here)
//   val_0_req_read_psum, r_addr_psum, r_data_psum
//                               psum read port (data one cycle after request)
//
// Optional feature (macro GLB_HOST_CYCLE_COUNT_EN)
//   Adds output cycle_count[31:0]. It clears on an accepted go and counts every
//   busy cycle until DONE, saturating at all-ones.
// -----------------------------------------------------------------------------
module glb_host_sequencer #(
    parameter int DATA_BITWIDTH  = 16,
    parameter int ADDR_BITWIDTH  = 6,
    parameter int W_LOAD_ADDR    = 0,
    parameter int A_LOAD_ADDR    = 10,
    parameter int PSUM_LOAD_ADDR = 0,
    parameter int X_dim          = 3,
    parameter int kernel_size    = 3,
    parameter int act_size       = 5,
    parameter int NUM_ITER       = 3,
    parameter int VAL_EXTRA      = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     write_en_wght,
    output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    output logic [DATA_BITWIDTH-1:0] w_data_wght,
    output logic                     write_en_iact,
    output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    output logic [DATA_BITWIDTH-1:0] w_data_iact,
    output logic                     val_enable_i_val_0_wght,
    output logic                     val_enable_i_val_0_iact,
    output logic                     start,
    input  logic                     load_done,
    input  logic                     compute_done,
    output logic                     val_0_req_read_psum,
    output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0] r_data_psum
`ifdef GLB_HOST_CYCLE_COUNT_EN
    ,
    output logic [31:0]              cycle_count
`endif
);

    typedef enum logic [3:0] {
        IDLE, WR_WGHT, WR_IACT, VAL_WGHT, WAIT_WLD, VAL_IACT, WAIT_ILD,
        START, WAIT_CMP, RD_REQ, RD_CAP, RD_OUT, DONE
    } state_t;

    localparam int CW = 16;

    // Terminal counts, pre-sized to the counter width.
    localparam logic [CW-1:0] WR_WGHT_LAST  = CW'(kernel_size * kernel_size - 1);
    localparam logic [CW-1:0] WR_IACT_LAST  = CW'(act_size * act_size - 1);
    localparam logic [CW-1:0] VAL_WGHT_LAST = CW'(kernel_size * kernel_size + VAL_EXTRA - 1);
    localparam logic [CW-1:0] VAL_IACT_LAST = CW'(act_size * act_size + VAL_EXTRA - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(X_dim - 1);
    localparam logic [CW-1:0] ITER_LAST     = CW'(NUM_ITER - 1);

    // Base addresses, reduced to address width so the sums wrap naturally.
    localparam logic [ADDR_BITWIDTH-1:0] W_BASE    = ADDR_BITWIDTH'(W_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH-1:0] A_BASE    = ADDR_BITWIDTH'(A_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH-1:0] PSUM_BASE = ADDR_BITWIDTH'(PSUM_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH-1:0] X_STRIDE  = ADDR_BITWIDTH'(X_dim);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;      // words written / enable cycles in current phase
    logic [CW-1:0]   iter;     // compute pass index
    logic [CW-1:0]   col;      // psum index within the pass
    logic            load_done_q, compute_done_q;
    logic            load_rise, compute_rise;
    logic            in_hs;

    // Only edges count, so a level left over from an earlier phase is ignored.
    assign load_rise    = load_done & ~load_done_q;
    assign compute_rise = compute_done & ~compute_done_q;
    assign in_hs        = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first; a path that
        // skipped an assignment would infer a latch.
        state_next              = state;
        busy                    = (state != IDLE);
        done                    = 1'b0;
        in_ready                = 1'b0;
        val_enable_i_val_0_wght = 1'b0;
        val_enable_i_val_0_iact = 1'b0;
        start                   = 1'b0;
        val_0_req_read_psum     = 1'b0;
        r_addr_psum             = '0;
        out_valid               = 1'b0;
        out_last                = 1'b0;

        case (state)
            IDLE:     if (go) state_next = WR_WGHT;
            WR_WGHT: begin
                in_ready = 1'b1;
                if (in_valid && cnt == WR_WGHT_LAST) state_next = WR_IACT;
            end
            WR_IACT: begin
                in_ready = 1'b1;
                if (in_valid && cnt == WR_IACT_LAST) state_next = VAL_WGHT;
            end
            VAL_WGHT: begin
                val_enable_i_val_0_wght = 1'b1;
                if (cnt == VAL_WGHT_LAST) state_next = WAIT_WLD;
            end
            WAIT_WLD: if (load_rise) state_next = VAL_IACT;
            VAL_IACT: begin
                val_enable_i_val_0_iact = 1'b1;
                if (cnt == VAL_IACT_LAST) state_next = WAIT_ILD;
            end
            WAIT_ILD: if (load_rise) state_next = START;
            START: begin
                start      = 1'b1;
                state_next = WAIT_CMP;
            end
            WAIT_CMP: if (compute_rise) state_next = RD_REQ;
            RD_REQ: begin
                val_0_req_read_psum = 1'b1;
                r_addr_psum = PSUM_BASE + ADDR_BITWIDTH'(iter) * X_STRIDE
                            + ADDR_BITWIDTH'(col);
                state_next  = RD_CAP;
            end
            RD_CAP:   state_next = RD_OUT;
            RD_OUT: begin
                out_valid = 1'b1;
                out_last  = (iter == ITER_LAST) && (col == COL_LAST);
                if (out_ready) begin
                    if (col != COL_LAST)       state_next = RD_REQ;
                    else if (iter != ITER_LAST) state_next = START;
                    else                        state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: the datapath registers (write ports, out_data) are reset as well,
    // so every output reads 0 while reset is asserted, including mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            iter           <= '0;
            col            <= '0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
            write_en_wght  <= 1'b0;
            w_addr_wght    <= '0;
            w_data_wght    <= '0;
            write_en_iact  <= 1'b0;
            w_addr_iact    <= '0;
            w_data_iact    <= '0;
            out_data       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples the
            // pre-edge values of cnt/iter/col regardless of statement order.
            load_done_q    <= load_done;
            compute_done_q <= compute_done;
            write_en_wght  <= 1'b0;
            write_en_iact  <= 1'b0;

            case (state)
                IDLE: if (go) begin
                    cnt  <= '0;
                    iter <= '0;
                    col  <= '0;
                end
                WR_WGHT: if (in_hs) begin
                    write_en_wght <= 1'b1;
                    w_addr_wght   <= W_BASE + ADDR_BITWIDTH'(cnt);
                    w_data_wght   <= in_data;
                    cnt           <= (cnt == WR_WGHT_LAST) ? '0 : cnt + 1'b1;
                end
                WR_IACT: if (in_hs) begin
                    write_en_iact <= 1'b1;
                    w_addr_iact   <= A_BASE + ADDR_BITWIDTH'(cnt);
                    w_data_iact   <= in_data;
                    cnt           <= (cnt == WR_IACT_LAST) ? '0 : cnt + 1'b1;
                end
                VAL_WGHT: cnt <= (cnt == VAL_WGHT_LAST) ? '0 : cnt + 1'b1;
                VAL_IACT: cnt <= (cnt == VAL_IACT_LAST) ? '0 : cnt + 1'b1;
                RD_CAP:   out_data <= r_data_psum;
                RD_OUT: if (out_ready) begin
                    if (col == COL_LAST) begin
                        col  <= '0;
                        iter <= iter + 1'b1;
                    end else begin
                        col  <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GLB_HOST_CYCLE_COUNT_EN
    // Counts busy cycles of one run; holds its value from DONE until next go.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else if (state == IDLE && go)
            cycle_count <= '0;
        else if (state != IDLE && state != DONE && cycle_count != 32'hFFFF_FFFF)
            cycle_count <= cycle_count + 32'd1;
    end
`else
    // Cycle counter not built.
`endif

endmodule

// File: tb/tb_glb_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_glb_host_sequencer
//
// Directed bench for glb_host_sequencer with default parameters. It loads 9
// weights (=1) and iacts 1..25, then drives load_done edges (including a stale
// high level). A small psum memory model returns addr*7. The bench applies
// backpressure, aborts one run with reset in WAIT_CMP and then reruns.
// -----------------------------------------------------------------------------
module tb_glb_host_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        write_en_wght;
    logic [5:0]  w_addr_wght;
    logic [15:0] w_data_wght;
    logic        write_en_iact;
    logic [5:0]  w_addr_iact;
    logic [15:0] w_data_iact;
    logic        val_enable_i_val_0_wght;
    logic        val_enable_i_val_0_iact;
    logic        start;
    logic        load_done;
    logic        compute_done;
    logic        val_0_req_read_psum;
    logic [5:0]  r_addr_psum;
    logic [15:0] r_data_psum;
`ifdef GLB_HOST_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    glb_host_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .go                      (go),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .out_last                (out_last),
        .busy                    (busy),
        .done                    (done),
        .write_en_wght           (write_en_wght),
        .w_addr_wght             (w_addr_wght),
        .w_data_wght             (w_data_wght),
        .write_en_iact           (write_en_iact),
        .w_addr_iact             (w_addr_iact),
        .w_data_iact             (w_data_iact),
        .val_enable_i_val_0_wght (val_enable_i_val_0_wght),
        .val_enable_i_val_0_iact (val_enable_i_val_0_iact),
        .start                   (start),
        .load_done               (load_done),
        .compute_done            (compute_done),
        .val_0_req_read_psum     (val_0_req_read_psum),
        .r_addr_psum             (r_addr_psum),
        .r_data_psum             (r_data_psum)
`ifdef GLB_HOST_CYCLE_COUNT_EN
        ,
        .cycle_count             (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors (sample on the falling edge) ----------------
    int          wr_w_n, wr_i_n, wen_n, ien_n, start_n, done_n, out_n, rd_n;
    int          hold_bad, stall_n;
    logic [21:0] wr_w_log [64];
    logic [21:0] wr_i_log [64];
    logic [15:0] out_log  [16];
    logic        last_log [16];
    logic [5:0]  rd_log   [16];
    logic        prev_stall;
    logic [15:0] prev_data;

    task automatic clear_logs();
        wr_w_n = 0; wr_i_n = 0; wen_n = 0; ien_n = 0; start_n = 0; done_n = 0;
        out_n = 0; rd_n = 0; hold_bad = 0; stall_n = 0;
    endtask

    always @(negedge clk) begin
        if (write_en_wght) begin
            if (wr_w_n < 64) wr_w_log[wr_w_n] = {w_addr_wght, w_data_wght};
            wr_w_n++;
        end
        if (write_en_iact) begin
            if (wr_i_n < 64) wr_i_log[wr_i_n] = {w_addr_iact, w_data_iact};
            wr_i_n++;
        end
        if (val_enable_i_val_0_wght) wen_n++;
        if (val_enable_i_val_0_iact) ien_n++;
        if (start) start_n++;
        if (done)  done_n++;
        if (val_0_req_read_psum) begin
            if (rd_n < 16) rd_log[rd_n] = r_addr_psum;
            rd_n++;
        end
        // A stalled word must still be offered, unchanged, with no new read.
        if (prev_stall && !(out_valid && out_data == prev_data && !val_0_req_read_psum))
            hold_bad++;
        if (out_valid && out_ready) begin
            if (out_n < 16) begin
                out_log[out_n]  = out_data;
                last_log[out_n] = out_last;
            end
            out_n++;
        end
        if (out_valid && !out_ready) stall_n++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    // ---------------- accelerator / GLB models ----------------
    logic       rq;
    logic [5:0] ra;
    initial begin
        r_data_psum = '0;
        forever begin
            @(negedge clk);
            rq = val_0_req_read_psum;
            ra = r_addr_psum;
            @(posedge clk);
            #1;
            // Data only valid in the cycle after a request; garbage otherwise.
            r_data_psum = rq ? 16'(ra) * 16'd7 : 16'hDEAD;
        end
    end

    initial begin
        compute_done = 1'b0;
        forever begin
            @(negedge clk);
            if (start) begin
                compute_done = 1'b0;
                repeat (4) @(negedge clk);
                compute_done = 1'b1;
            end
        end
    end

    // ---------------- sequences ----------------
    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, in_ready, out_valid, out_last, write_en_wght,
                             write_en_iact, val_enable_i_val_0_wght,
                             val_enable_i_val_0_iact, start, val_0_req_read_psum}, 0);
        check({tag, "_addr"}, {w_addr_wght, w_addr_iact, r_addr_psum}, 0);
        check({tag, "_wdata"}, {w_data_wght, w_data_iact}, 0);
        check({tag, "_odata"}, out_data, 0);
    endtask

    task automatic load_phase(input bit rnd_valid);
        int idx;
        int g;
        bit hs;
        clear_logs();
        go = 1'b1;
        step();
        go = 1'b0;

        idx = 0;
        g   = 0;
        while (idx < 34 && g < 1000) begin
            in_data  = (idx < 9) ? 16'd1 : 16'(idx - 8);
            in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            hs       = in_valid && in_ready;
            step();
            if (hs) idx++;
            g++;
        end
        in_valid = 1'b0;
        check("feed_count", idx, 34);
        check("in_ready_drop", in_ready, 0);

        g = 0;
        while (!(wen_n > 0 && !val_enable_i_val_0_wght) && g < 100) begin
            step();
            g++;
        end
        check("wen_timeout", g < 100, 1);
        check("wen_len", wen_n, 12);

        check("wr_w_count", wr_w_n, 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("wr_w_%0d", i), wr_w_log[i], {6'(i), 16'd1});
        check("wr_i_count", wr_i_n, 25);
        for (int i = 0; i < 25; i++)
            check($sformatf("wr_i_%0d", i), wr_i_log[i], {6'(10 + i), 16'(i + 1)});

        repeat (3) step();
        check("wld_stall", ien_n, 0);
        if (load_done) begin
            load_done = 1'b0;
            repeat (2) step();
            check("wld_stale_stall", ien_n, 0);
        end
        load_done = 1'b1;

        g = 0;
        while (!(ien_n > 0 && !val_enable_i_val_0_iact) && g < 100) begin
            step();
            g++;
        end
        check("ien_timeout", g < 100, 1);
        check("ien_len", ien_n, 28);

        // load_done is still high from the weight phase: must not advance.
        repeat (5) step();
        check("ild_stale_stall", start_n, 0);
        load_done = 1'b0;
        step();
        load_done = 1'b1;
    endtask

    task automatic finish_phase();
        int g;
        g = 0;
        while (out_n < 4 && g < 300) begin
            step();
            g++;
        end
        check("out4_timeout", g < 300, 1);
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        go = 1'b1;          // ignored while busy
        step();
        go = 1'b0;

        g = 0;
        while (done_n < 1 && g < 500) begin
            step();
            g++;
        end
        check("done_timeout", g < 500, 1);
        repeat (2) step();
        check("busy_after_done", busy, 0);
        check("done_pulses", done_n, 1);
        check("start_pulses", start_n, 3);
        check("out_count", out_n, 9);
        check("rd_count", rd_n, 9);
        check("hold_bad", hold_bad, 0);
        check("stall_seen", stall_n > 0, 1);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("rd_addr_%0d", k), rd_log[k], 6'(k));
            check($sformatf("out_data_%0d", k), out_log[k], 16'(k * 7));
            check($sformatf("out_last_%0d", k), last_log[k], (k == 8));
        end
    endtask

    initial begin
        int g;
        reset     = 1'b1;
        go        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        load_done = 1'b0;
        clear_logs();
        prev_stall = 1'b0;
        prev_data  = '0;
        repeat (3) step();
        check_zero("reset0");
        reset = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Run 1: random in_valid, load_done stuck high through the weight phase.
        load_done = 1'b1;
        load_phase(1'b1);
        finish_phase();

        // Run 2: abort with reset while waiting for compute_done.
        load_done = 1'b0;
        load_phase(1'b0);
        g = 0;
        while (start_n < 1 && g < 100) begin
            step();
            g++;
        end
        check("start_timeout", g < 100, 1);
        repeat (2) step();
        check("pre_abort_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_zero("abort");
        step();
        reset = 1'b0;
        step();

        // Run 3: full rerun after the abort.
        load_done = 1'b0;
        load_phase(1'b0);
        finish_phase();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
